i2c_reg_bank: RTL

//  - Application-side register bank directly downstream of the I2C slave. It consumes the

---
 rtl/i2c_reg_bank.sv | 112 +++++++++++
 1 files changed

// File: rtl/i2c_reg_bank.sv
// Application-side register bank behind the I2C slave: R/W control regs, ID, synced status,
// write counter, and sticky event flags with interrupt when I2C_REGBANK_IRQ_EN is defined.
module i2c_reg_bank #(
    parameter int         NUM_CTRL   = 4,
    parameter logic [7:0] CTRL_RESET = 8'h00,
    parameter logic [7:0] ID_VALUE   = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rw,
    input  logic [7:0]            addr,
    input  logic                  wen,
    input  logic [7:0]            wdata,
    input  logic                  rdata_used,
    output logic [7:0]            rdata,
    output logic [8*NUM_CTRL-1:0] ctrl_o,
    input  logic [7:0]            status_i,
    input  logic [7:0]            evt_i,
    output logic                  irq
);
    localparam logic [7:0] ADDR_ID   = 8'h10;
    localparam logic [7:0] ADDR_STAT = 8'h11;
    localparam logic [7:0] ADDR_EVT  = 8'h12;
    localparam logic [7:0] ADDR_WCNT = 8'h13;

    logic [NUM_CTRL-1:0][7:0] ctrl_q, ctrl_d;
    logic [7:0]               stat_s1_q, stat_s2_q;
    logic [7:0]               wcnt_q, wcnt_d;
    logic [7:0]               rdata_q, rdata_d;
    logic [7:0]               evt_rd;

    always_comb begin
        ctrl_d = ctrl_q;
        for (int k = 0; k < NUM_CTRL; k++)
            if (wen && addr == 8'(k)) ctrl_d[k] = wdata;
        wcnt_d = wen ? wcnt_q + 8'd1 : wcnt_q;
    end

    always_comb begin
        rdata_d = 8'h00;
        for (int k = 0; k < NUM_CTRL; k++)
            if (addr == 8'(k)) rdata_d = ctrl_q[k];
        case (addr)
            ADDR_ID:   rdata_d = ID_VALUE;
            ADDR_STAT: rdata_d = stat_s2_q;
            ADDR_EVT:  rdata_d = evt_rd;
            ADDR_WCNT: rdata_d = wcnt_q;
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q    <= {NUM_CTRL{CTRL_RESET}};
            stat_s1_q <= 8'h00;
            stat_s2_q <= 8'h00;
            wcnt_q    <= 8'h00;
            rdata_q   <= 8'h00;
        end else begin
            ctrl_q    <= ctrl_d;
            stat_s1_q <= status_i;
            stat_s2_q <= stat_s1_q;
            wcnt_q    <= wcnt_d;
            rdata_q   <= rdata_d;
        end
    end

    assign ctrl_o = ctrl_q;
    assign rdata  = rdata_q;

`ifdef I2C_REGBANK_IRQ_EN
    logic [7:0] evt_s1_q, evt_s2_q, evt_prev_q, evt_q, evt_d, evt_clr, raddr_q;
    logic       irq_q;
    logic       unused_in;

    // The slave bumps addr in the same cycle it captures rdata, so read-clear keys off
    // the address that produced rdata, not the live one. Set beats clear on a shared bit.
    always_comb begin
        evt_clr = 8'h00;
        if (wen && addr == ADDR_EVT)            evt_clr = evt_clr | wdata;
        if (rdata_used && raddr_q == ADDR_EVT)  evt_clr = evt_clr | rdata_q;
        evt_d = (evt_q & ~evt_clr) | (evt_s2_q & ~evt_prev_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            evt_s1_q   <= 8'h00;
            evt_s2_q   <= 8'h00;
            evt_prev_q <= 8'h00;
            evt_q      <= 8'h00;
            raddr_q    <= 8'h00;
            irq_q      <= 1'b0;
        end else begin
            evt_s1_q   <= evt_i;
            evt_s2_q   <= evt_s1_q;
            evt_prev_q <= evt_s2_q;
            evt_q      <= evt_d;
            raddr_q    <= addr;
            irq_q      <= |evt_q;
        end
    end

    assign evt_rd    = evt_q;
    assign irq       = irq_q;
    assign unused_in = rw;
`else
    logic unused_in;
    assign evt_rd    = 8'h00;
    assign irq       = 1'b0;
    assign unused_in = ^{rw, rdata_used, evt_i};
`endif
endmodule
